// File: rtl/debug_frame_arbiter.sv
// Shares the debug UART write port between NSRC frame sources, forwarding tagged frames round-robin.
// Latency: a frame written at edge E is in wdata with wreq high from E+1.
// Backpressure: wreq/wdata hold while wgnt is low; sources cannot be stalled, and full FIFOs count drops instead.

// Small FIFO with storage in a register array. The head is read combinationally.
// Latency: a push is visible at the head on the next cycle. Pushing while full is only legal together with a pop.
// Backpressure: none inside; the caller gates push with full/pop.
module dfa_fifo #(
    parameter int W     = 8,
    parameter int DEPTH = 2
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         push,
    input  logic [W-1:0] din,
    input  logic         pop,
    output logic [W-1:0] dout,
    output logic         empty,
    output logic         full
);
    localparam int AW = $clog2(DEPTH);

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW:0]   cnt;

    assign dout  = mem[rd_ptr];
    assign empty = (cnt == '0);
    assign full  = (cnt == (AW+1)'(DEPTH));

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= din;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            if (push && !pop) begin
                cnt <= cnt + (AW+1)'(1);
            end else if (pop && !push) begin
                cnt <= cnt - (AW+1)'(1);
            end
        end
    end
endmodule

module debug_frame_arbiter #(
    parameter int         NSRC     = 2,
    parameter int         FRAME_W  = 48,
    parameter int         DEPTH    = 2,
    parameter logic [7:0] TAG_DATA = 8'hA0,
    parameter logic [7:0] TAG_DROP = 8'hE0
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [NSRC-1:0]         src_en,
    input  logic [NSRC*FRAME_W-1:0] src_data,
    output logic                    wreq,
    input  logic                    wgnt,
    output logic [FRAME_W+7:0]      wdata,
    output logic                    drop_flag
);
    localparam int PW = (NSRC > 1) ? $clog2(NSRC) : 1;
    localparam int OW = FRAME_W + 8;

    logic               load;
    logic               win_vld;
    logic [PW-1:0]      win;
    logic [PW-1:0]      rr_ptr;
    logic [PW-1:0]      rr_nxt;
    logic [NSRC-1:0]    req_vld;
    logic [NSRC-1:0]    fifo_empty;
    logic [NSRC-1:0]    fifo_full;
    logic [NSRC-1:0]    fifo_push;
    logic [NSRC-1:0]    fifo_pop;
    logic [NSRC-1:0]    rpt_clr;
    logic [NSRC-1:0]    drop;
    logic [NSRC-1:0]    cnt_nz;
    logic [FRAME_W-1:0] fifo_dat [NSRC];
    logic [OW-1:0]      req_dat  [NSRC];
    logic [7:0]         drop_cnt [NSRC];

    // The output register reloads whenever it is idle or its frame is being taken.
    assign load = !wreq || wgnt;

    // Scan from the highest offset down so the requester closest to rr_ptr wins.
    always_comb begin : rr_pick
        logic [PW:0] slot;
        slot    = '0;
        win_vld = 1'b0;
        win     = '0;
        for (int k = NSRC - 1; k >= 0; k--) begin
            slot = {1'b0, rr_ptr} + (PW+1)'(k);
            if (slot >= (PW+1)'(NSRC)) begin
                slot = slot - (PW+1)'(NSRC);
            end
            if (req_vld[slot[PW-1:0]]) begin
                win_vld = 1'b1;
                win     = slot[PW-1:0];
            end
        end
        rr_nxt = (int'(win) == NSRC - 1) ? '0 : win + PW'(1);
    end

    for (genvar i = 0; i < NSRC; i++) begin : g_src
        logic [FRAME_W-1:0] frm;
        logic               frm_vld;
        logic               won;

        assign frm     = src_data[i*FRAME_W +: FRAME_W];
        assign frm_vld = src_en[i] && (frm != '0);
        assign won     = load && win_vld && (win == PW'(i));

        assign fifo_pop[i]  = won && !fifo_empty[i];
        assign rpt_clr[i]   = won && fifo_empty[i];
        // Fullness is judged after this cycle's pop.
        assign fifo_push[i] = frm_vld && (!fifo_full[i] || fifo_pop[i]);
        assign drop[i]      = frm_vld && !fifo_push[i];
        assign cnt_nz[i]    = (drop_cnt[i] != 8'd0);
        // Reports only go out from an empty FIFO, so they never overtake older data.
        assign req_vld[i]   = !fifo_empty[i] || cnt_nz[i];
        assign req_dat[i]   = fifo_empty[i]
                            ? {TAG_DROP + 8'(i), {(FRAME_W-8){1'b0}}, drop_cnt[i]}
                            : {TAG_DATA + 8'(i), fifo_dat[i]};

        dfa_fifo #(
            .W     (FRAME_W),
            .DEPTH (DEPTH)
        ) u_fifo (
            .clk   (clk),
            .rst_n (rst_n),
            .push  (fifo_push[i]),
            .din   (frm),
            .pop   (fifo_pop[i]),
            .dout  (fifo_dat[i]),
            .empty (fifo_empty[i]),
            .full  (fifo_full[i])
        );

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                drop_cnt[i] <= 8'd0;
            end else if (rpt_clr[i]) begin
                drop_cnt[i] <= drop[i] ? 8'd1 : 8'd0;
            end else if (drop[i] && drop_cnt[i] != 8'hFF) begin
                drop_cnt[i] <= drop_cnt[i] + 8'd1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wreq      <= 1'b0;
            wdata     <= '0;
            rr_ptr    <= '0;
            drop_flag <= 1'b0;
        end else begin
            drop_flag <= |cnt_nz;
            if (load) begin
                if (win_vld) begin
                    wreq   <= 1'b1;
                    wdata  <= req_dat[win];
                    rr_ptr <= rr_nxt;
                end else begin
                    wreq <= 1'b0;
                end
            end
        end
    end
endmodule

// File: tb/tb_debug_frame_arbiter.sv
// Bench for debug_frame_arbiter: a table of single-frame vectors plus scripted multi-cycle sequences.
// Expected UART words are queued as stimulus is driven and compared on every wreq&wgnt handshake.
module tb_debug_frame_arbiter;
    localparam int NSRC = 2;
    localparam int FW   = 48;
    localparam int OW   = FW + 8;

    logic                 clk      = 1'b0;
    logic                 rst_n    = 1'b0;
    logic [NSRC-1:0]      src_en   = '0;
    logic [NSRC*FW-1:0]   src_data = '0;
    logic                 wgnt     = 1'b0;
    logic                 wreq;
    logic [OW-1:0]        wdata;
    logic                 drop_flag;

    always #5 clk = ~clk;

    debug_frame_arbiter #(
        .NSRC     (NSRC),
        .FRAME_W  (FW),
        .DEPTH    (2),
        .TAG_DATA (8'hA0),
        .TAG_DROP (8'hE0)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .src_en    (src_en),
        .src_data  (src_data),
        .wreq      (wreq),
        .wgnt      (wgnt),
        .wdata     (wdata),
        .drop_flag (drop_flag)
    );

    int            n_tests = 0;
    int            n_fail  = 0;
    logic [OW-1:0] exp_q[$];

    typedef struct {
        int            src;
        logic [FW-1:0] data;
        logic [OW-1:0] exp;
    } vec_t;
    vec_t vecs[4];

    function automatic void check(string name, logic [63:0] act, logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endfunction

    // Scoreboard: every accepted word must be the next expected one.
    always @(negedge clk) begin
        if (rst_n && wreq && wgnt) begin
            if (exp_q.size() == 0) begin
                check("unexpected_word", 64'(wdata), 64'(0));
            end else begin
                check("sb_word", 64'(wdata), 64'(exp_q.pop_front()));
            end
        end
    end

    // Inputs change 1ns after the rising edge; outputs are read there or at the falling edge.
    task automatic tick(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic put(input int s, input logic [FW-1:0] d);
        src_en[s]              = 1'b1;
        src_data[s*FW +: FW]   = d;
    endtask

    task automatic clr();
        src_en   = '0;
        src_data = '0;
    endtask

    task automatic pulse(input int s, input logic [FW-1:0] d);
        put(s, d);
        tick();
        clr();
    endtask

    task automatic drain(input string name, input int budget);
        int b;
        b    = budget;
        wgnt = 1'b1;
        while (exp_q.size() != 0 && b > 0) begin
            tick();
            b--;
        end
        check(name, 64'(exp_q.size()), 64'(0));
        tick(2);
        check({name, "_idle"}, 64'(wreq), 64'(0));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want completion");
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0] = '{0, 48'h0011_2233_4455, 56'hA0_0011_2233_4455};
        vecs[1] = '{1, 48'hFFFF_FFFF_FFFF, 56'hA1_FFFF_FFFF_FFFF};
        vecs[2] = '{0, 48'h0000_0000_0001, 56'hA0_0000_0000_0001};
        vecs[3] = '{1, 48'h8000_0000_0000, 56'hA1_8000_0000_0000};

        tick(2);
        check("rst_wreq", 64'(wreq), 64'(0));
        check("rst_wdata", 64'(wdata), 64'(0));
        check("rst_drop_flag", 64'(drop_flag), 64'(0));
        rst_n = 1'b1;
        tick();

        // Single frames: wreq rises one edge after sampling and lasts one cycle.
        wgnt = 1'b1;
        for (int v = 0; v < 4; v++) begin
            exp_q.push_back(vecs[v].exp);
            pulse(vecs[v].src, vecs[v].data);
            check("lat_before", 64'(wreq), 64'(0));
            tick();
            check("lat_wreq", 64'(wreq), 64'(1));
            check("lat_wdata", 64'(wdata), 64'(vecs[v].exp));
            tick();
            check("lat_one_cycle", 64'(wreq), 64'(0));
            tick();
        end

        // Round-robin between two sources with wgnt held low first.
        wgnt = 1'b0;
        exp_q.push_back(56'hA0_0000_0000_00A1);
        exp_q.push_back(56'hA1_0000_0000_00B1);
        exp_q.push_back(56'hA0_0000_0000_00A2);
        exp_q.push_back(56'hA1_0000_0000_00B2);
        put(0, 48'h00A1);
        put(1, 48'h00B1);
        tick();
        clr();
        put(0, 48'h00A2);
        put(1, 48'h00B2);
        tick();
        clr();
        for (int c = 0; c < 3; c++) begin
            check("rr_hold", {7'd0, wreq, wdata}, {8'h01, 56'hA0_0000_0000_00A1});
            tick();
        end
        drain("rr_drain", 20);

        // Overflow: S0's frame occupies wdata, so S1 keeps 2 of 5 and drops 3.
        wgnt = 1'b0;
        exp_q.push_back(56'hA0_0000_0000_0C00);
        exp_q.push_back(56'hA1_0000_0000_0C01);
        exp_q.push_back(56'hA1_0000_0000_0C02);
        exp_q.push_back(56'hE1_0000_0000_0003);
        pulse(0, 48'h0C00);
        tick();
        for (int f = 1; f <= 5; f++) begin
            pulse(1, FW'(48'h0C00 + f));
        end
        tick();
        check("ovf_drop_flag", 64'(drop_flag), 64'(1));
        drain("ovf_drain", 20);
        check("ovf_flag_clear", 64'(drop_flag), 64'(0));

        // Saturation: 300 drops on S0 report 255.
        wgnt = 1'b0;
        exp_q.push_back(56'hA0_0000_0000_0F01);
        exp_q.push_back(56'hA0_0000_0000_0F02);
        exp_q.push_back(56'hA0_0000_0000_0F03);
        exp_q.push_back(56'hE0_0000_0000_00FF);
        pulse(0, 48'h0F01);
        pulse(0, 48'h0F02);
        pulse(0, 48'h0F03);
        put(0, 48'hDEAD_0000_0001);
        tick(300);
        clr();
        tick();
        check("sat_drop_flag", 64'(drop_flag), 64'(1));
        wgnt = 1'b1;
        tick(3);
        wgnt = 1'b0;
        check("sat_report", {7'd0, wreq, wdata}, {8'h01, 56'hE0_0000_0000_00FF});
        // A drop needs a full FIFO and a report needs an empty one, so the nearest
        // reachable case is a drop while the first report is still held in wdata.
        exp_q.push_back(56'hA0_0000_0000_0E01);
        exp_q.push_back(56'hA0_0000_0000_0E02);
        exp_q.push_back(56'hE0_0000_0000_0001);
        pulse(0, 48'h0E01);
        pulse(0, 48'h0E02);
        pulse(0, 48'h0E03);
        drain("sat_drain", 20);

        // All-zero frames are neither stored nor counted.
        wgnt = 1'b1;
        pulse(1, 48'h0);
        tick();
        check("zero_no_wreq", 64'(wreq), 64'(0));
        tick();
        check("zero_no_drop", 64'(drop_flag), 64'(0));

        // Full FIFO popped and written on the same edge: no drop.
        wgnt = 1'b0;
        exp_q.push_back(56'hA0_0000_0000_0D01);
        exp_q.push_back(56'hA0_0000_0000_0D02);
        exp_q.push_back(56'hA0_0000_0000_0D03);
        exp_q.push_back(56'hA0_0000_0000_0D04);
        pulse(0, 48'h0D01);
        pulse(0, 48'h0D02);
        pulse(0, 48'h0D03);
        put(0, 48'h0D04);
        wgnt = 1'b1;
        tick();
        clr();
        drain("fullpop_drain", 20);
        check("fullpop_no_drop", 64'(drop_flag), 64'(0));

        // Asynchronous reset with wreq high, then a frame presented during reset.
        wgnt = 1'b0;
        pulse(0, 48'h0B01);
        pulse(1, 48'h0B02);
        check("rst_pre_wreq", 64'(wreq), 64'(1));
        #2;
        rst_n = 1'b0;
        #1;
        check("rst_async_wreq", 64'(wreq), 64'(0));
        exp_q.delete();
        tick();
        put(0, 48'h0B03);
        tick(2);
        clr();
        rst_n = 1'b1;
        wgnt  = 1'b1;
        for (int c = 0; c < 5; c++) begin
            tick();
            check("rst_no_stale", 64'(wreq), 64'(0));
        end
        check("rst_drop_flag", 64'(drop_flag), 64'(0));

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
